// File: rtl/yutorina_bus_rr_arbiter.sv
// Round-robin arbiter for the four-master Yutorina bus, with tenure-limited handover
// and an optional slave watchdog built when YUTORINA_BUS_WATCHDOG_EN is defined.
module yutorina_bus_rr_arbiter #(
   parameter int MAX_TENURE = 16,
   parameter int TIMEOUT    = 64
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       master0_request_,
   input  logic       master1_request_,
   input  logic       master2_request_,
   input  logic       master3_request_,
   output logic       master0_grant_,
   output logic       master1_grant_,
   output logic       master2_grant_,
   output logic       master3_grant_,
   output logic [1:0] bus_owner,
   output logic       bus_busy,
   input  logic       slave_address_strobe_,
   input  logic       master_ready_,
   output logic       timeout_ready_,
   output logic       bus_error
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OWNED = 1'b1
   } state_e;

   state_e     state_q, state_d;
   logic [1:0] owner_q, owner_d;
   logic [1:0] last_q, last_d;
   logic [7:0] tenure_q, tenure_d;
   logic [3:0] req;
   logic [3:0] owner_onehot;
   logic [3:0] grant_n;
   logic [2:0] pick;
   logic       preempt;

   assign req = ~{master3_request_, master2_request_, master1_request_, master0_request_};

   // Returns {found, index}; the search starts after `last` and wraps back to it.
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last,
                                          input logic skip_last);
      logic [2:0] result;
      logic [1:0] cand;
      result = '0;
      for (int unsigned i = 1; i <= 4; i++) begin
         cand = last + 2'(i);
         if (!result[2] && r[cand] && !(skip_last && i == 4)) begin
            result = {1'b1, cand};
         end
      end
      return result;
   endfunction

   always_comb begin
      owner_onehot = '0;
      owner_onehot[owner_q] = 1'b1;
   end

   always_comb begin
      preempt = (MAX_TENURE != 0) && (tenure_q >= 8'(MAX_TENURE)) &&
                (|(req & ~owner_onehot)) && slave_address_strobe_;
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      tenure_d = tenure_q;
      pick     = '0;
      case (state_q)
         ST_IDLE: begin
            pick = rr_pick(req, last_q, 1'b0);
            if (pick[2]) begin
               state_d  = ST_OWNED;
               owner_d  = pick[1:0];
               last_d   = pick[1:0];
               tenure_d = '0;
            end
         end
         ST_OWNED: begin
            if (!req[owner_q] || preempt) begin
               // Release and preemption share one handover path with no dead cycle.
               pick     = rr_pick(req, last_q, 1'b1);
               tenure_d = '0;
               if (pick[2]) begin
                  owner_d = pick[1:0];
                  last_d  = pick[1:0];
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (tenure_q != '1) begin
               tenure_d = tenure_q + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         owner_q  <= '0;
         last_q   <= 2'd3;
         tenure_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         tenure_q <= tenure_d;
      end
   end

   always_comb begin
      grant_n = '1;
      if (state_q == ST_OWNED) begin
         grant_n[owner_q] = 1'b0;
      end
   end

   assign master0_grant_ = grant_n[0];
   assign master1_grant_ = grant_n[1];
   assign master2_grant_ = grant_n[2];
   assign master3_grant_ = grant_n[3];
   assign bus_owner      = owner_q;
   assign bus_busy       = (state_q == ST_OWNED);

`ifdef YUTORINA_BUS_WATCHDOG_EN
   logic [7:0] wd_q, wd_d;
   logic       wd_hit;

   // Abort is decoded from the stored count so a same-cycle ready still wins.
   always_comb begin
      wd_hit = !slave_address_strobe_ && master_ready_ && (wd_q == 8'(TIMEOUT - 1));
      if (slave_address_strobe_ || !master_ready_ || wd_hit) begin
         wd_d = '0;
      end else begin
         wd_d = wd_q + 8'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wd_q <= '0;
      end else begin
         wd_q <= wd_d;
      end
   end

   assign timeout_ready_ = !wd_hit;
   assign bus_error      = wd_hit;
`else
   logic unused_master_ready;
   assign unused_master_ready = master_ready_;
   assign timeout_ready_      = 1'b1;
   assign bus_error          = 1'b0;
`endif

endmodule

// File: tb/tb_yutorina_bus_rr_arbiter.sv
// Directed and random checks of yutorina_bus_rr_arbiter against a cycle-level reference
// model; watchdog expectations follow YUTORINA_BUS_WATCHDOG_EN.
module tb_yutorina_bus_rr_arbiter;

   localparam int MT = 4;
   localparam int TO = 8;
`ifdef YUTORINA_BUS_WATCHDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] req_n;
   logic       strobe_n, ready_n;
   logic       g0, g1, g2, g3;
   logic [1:0] bus_owner;
   logic       bus_busy, timeout_ready_, bus_error;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   int m_busy, m_owner, m_last, m_ten, m_run;
   // observations captured at the last sample point
   logic obs_err;

   always #5 clock = ~clock;

   yutorina_bus_rr_arbiter #(.MAX_TENURE(MT), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset),
      .master0_request_(req_n[0]), .master1_request_(req_n[1]),
      .master2_request_(req_n[2]), .master3_request_(req_n[3]),
      .master0_grant_(g0), .master1_grant_(g1), .master2_grant_(g2), .master3_grant_(g3),
      .bus_owner(bus_owner), .bus_busy(bus_busy),
      .slave_address_strobe_(strobe_n), .master_ready_(ready_n),
      .timeout_ready_(timeout_ready_), .bus_error(bus_error)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_owner = 0; m_last = 3; m_ten = 0; m_run = 0;
   endtask

   // first requester after `last` in rotating order; -1 if none
   function automatic int next_req(input logic [3:0] r, input int last, input bit incl_last);
      for (int k = 1; k <= 4; k++) begin
         int c;
         c = (last + k) % 4;
         if (k == 4 && !incl_last) return -1;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   // one clock: drive, sample mid-cycle against the model, advance the model, pass the edge
   task automatic tick(input logic [3:0] rq_n, input logic stb_n, input logic rdy_n);
      logic [3:0] r, exp_g;
      bit stall, exp_err, others;
      int run_cur, w;
      req_n = rq_n; strobe_n = stb_n; ready_n = rdy_n;
      @(negedge clock);
      r = ~rq_n;
      stall   = !stb_n && rdy_n;
      run_cur = stall ? m_run + 1 : 0;
      exp_err = WD_EN && stall && (run_cur % TO == 0);
      exp_g = 4'hF;
      if (m_busy != 0) exp_g[m_owner] = 1'b0;
      check("grants", {g3, g2, g1, g0}, exp_g);
      check("bus_busy", bus_busy, m_busy);
      if (m_busy != 0) check("bus_owner", bus_owner, m_owner);
      check("timeout_ready_", timeout_ready_, !exp_err);
      check("bus_error", bus_error, exp_err);
      obs_err = bus_error;
      m_run = run_cur;
      if (m_busy == 0) begin
         w = next_req(r, m_last, 1'b1);
         if (w >= 0) begin m_busy = 1; m_owner = w; m_last = w; m_ten = 0; end
      end else begin
         others = (r & ~(4'b1 << m_owner)) != 4'b0;
         if (!r[m_owner] || (MT != 0 && m_ten >= MT && others && stb_n)) begin
            w = next_req(r, m_last, 1'b0);
            m_ten = 0;
            if (w >= 0) begin m_owner = w; m_last = w; end
            else m_busy = 0;
         end else if (m_ten < 255) begin
            m_ten++;
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      int order[6];
      int n_order, prev, held, all_high, first_err, errs;
      logic [3:0] rq;
      reset = 1'b1; req_n = 4'hF; strobe_n = 1'b1; ready_n = 1'b1;
      model_reset();
      @(posedge clock); #1;
      do_reset();

      // reset state and first grant latency
      check("reset_owner", bus_owner, 2'd0);
      check("reset_busy", bus_busy, 1'b0);
      tick(4'hF, 1'b1, 1'b1);
      tick(4'hF, 1'b1, 1'b1);
      tick(4'hF, 1'b1, 1'b1);
      tick(4'b1011, 1'b1, 1'b1);
      check("m2_grant", g2, 1'b0);
      check("m2_owner", bus_owner, 2'd2);
      check("m2_busy", bus_busy, 1'b1);
      tick(4'b1011, 1'b1, 1'b1);
      tick(4'hF, 1'b1, 1'b1);

      // masters 0,1,3 rotate, each releasing for one cycle after its tenure
      do_reset();
      n_order = 0; prev = -1; all_high = 0;
      for (int c = 0; c < 40; c++) begin
         rq = 4'b0100;
         if (m_busy != 0 && m_ten == 4) rq[m_owner] = 1'b1;
         tick(rq, 1'b1, 1'b1);
         if (!bus_busy) all_high++;
         if (bus_busy && int'(bus_owner) != prev) begin
            prev = bus_owner;
            if (n_order < 6) begin order[n_order] = prev; n_order++; end
         end
      end
      check("rotation_count", n_order, 6);
      for (int i = 0; i < 6; i++) begin
         int exp_o[6];
         exp_o = '{0, 1, 3, 0, 1, 3};
         check("rotation_order", order[i], exp_o[i]);
      end
      check("no_idle_gap", all_high, 0);

      // tenure preemption with strobe high: master0 loses after MT+1 grant cycles
      do_reset();
      tick(4'b1110, 1'b1, 1'b1);
      held = 0;
      for (int c = 0; c < 20 && bus_owner != 2'd1; c++) begin
         held++;
         tick(4'b1100, 1'b1, 1'b1);
      end
      check("preempt_held", held, MT + 1);
      check("preempt_owner", bus_owner, 2'd1);

      // same with a transfer in flight: no preemption until strobe rises
      do_reset();
      tick(4'b1110, 1'b0, 1'b0);
      for (int c = 0; c < 12; c++) tick(4'b1100, 1'b0, 1'b0);
      check("no_preempt_mid_xfer", bus_owner, 2'd0);
      tick(4'b1100, 1'b1, 1'b1);
      check("preempt_after_strobe", bus_owner, 2'd1);
      tick(4'hF, 1'b1, 1'b1);

      // watchdog: abort in the TO-th stalled cycle, then restart
      first_err = 0; errs = 0;
      for (int c = 1; c <= 3 * TO; c++) begin
         tick(4'hF, 1'b0, 1'b1);
         if (obs_err) begin errs++; if (first_err == 0) first_err = c; end
      end
      check("wd_first_abort", first_err, WD_EN ? TO : 0);
      check("wd_abort_count", errs, WD_EN ? 3 : 0);
      tick(4'hF, 1'b1, 1'b1);
      errs = 0;
      for (int c = 1; c <= 6; c++) begin
         tick(4'hF, (c == 6), (c != 5));
         errs += obs_err;
      end
      for (int c = 1; c <= TO; c++) begin
         tick(4'hF, 1'b0, (c != TO));
         errs += obs_err;
      end
      check("wd_ready_wins", errs, 0);
      tick(4'hF, 1'b1, 1'b1);

      // asynchronous reset while master1 owns the bus mid-transfer
      for (int c = 0; c < 3; c++) tick(4'b1101, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_grants", {g3, g2, g1, g0}, 4'hF);
      check("async_rst_busy", bus_busy, 1'b0);
      model_reset();
      @(posedge clock); #1;
      reset = 1'b0;
      tick(4'b1101, 1'b1, 1'b1);
      check("rst_regrant_owner", bus_owner, 2'd1);
      check("rst_regrant_busy", bus_busy, 1'b1);
      tick(4'hF, 1'b1, 1'b1);

      // long stall: watchdog aborts only when built in
      for (int c = 0; c < 300; c++) tick(4'hF, 1'b0, 1'b1);
      tick(4'hF, 1'b1, 1'b1);

      // random traffic
      for (int c = 0; c < 600; c++) begin
         tick(4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
